id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between decode (ID) and execute (EX).
- Latches the decoded instruction fields and operands that feed the execute-control and ALU logic.
- Inserts a single bubble on a load-use hazard, honours downstream stall and branch flush, and provides same-cycle write-back bypass of operands captured from ID.

Parameters:
- XLEN, 32, datapath width of pc, data1, data2, imm, wb_data.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- stall_in  input  1  downstream stall (memory busy); hold EX contents
- flush  input  1  taken branch/jump resolved in EX; kill the instruction entering EX
- id_valid  input  1  ID holds a real instruction
- id_pc  input  XLEN  instruction address
- id_ir_type  input  4  instruction class code (`*_IR constants)
- id_funct3  input  3  funct3 field
- id_funct7  input  7  funct7 field
- id_rs1, id_rs2, id_rd  input  5 each  register indices
- id_uses_rs1, id_uses_rs2  input  1 each  instruction reads rs1/rs2
- id_reg_we  input  1  instruction writes rd
- id_data1, id_data2  input  XLEN  register-file read data
- id_imm  input  XLEN  decoded immediate
- wb_we  input  1  write-back stage writing register file this cycle
- wb_rd  input  5  write-back destination
- wb_data  input  XLEN  write-back value
- id_stall  output  1  hold IF/ID this cycle (combinational)
- ex_valid  output  1  EX holds a real instruction
- ex_pc, ex_data1, ex_data2, ex_imm  output  XLEN  registered copies
- ex_ir_type, ex_funct3, ex_funct7, ex_rd, ex_reg_we  output  4/3/7/5/1  registered copies

Behaviour:
- Reset (rst_n low, asynchronous): all ex_* outputs are bubble values: ex_valid=0, ex_ir_type=`REG_IMM_IR, ex_funct3=`ADD_FUNCT3, ex_funct7=0, ex_rd=0, ex_reg_we=0, ex_pc/ex_data1/ex_data2/ex_imm=0. Same values define "bubble" below.
- load_use = ex_valid & (ex_ir_type==`LOAD_IR) & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- id_stall = !flush & (stall_in | load_use). Purely combinational, no added latency.
- Per rising edge, priority order:
  1. flush: load bubble; id_stall=0. Flush wins over stall_in and load_use.
  2. stall_in: hold all ex_* unchanged.
  3. load_use: load bubble; the ID instruction stays in ID (id_stall=1).
  4. Otherwise: capture ID fields. If id_valid=0, load a bubble instead. ex_reg_we = id_reg_we & id_valid.
- WB bypass at capture: ex_data1 = (wb_we & wb_rd!=0 & wb_rd==id_rs1) ? wb_data : id_data1. ex_data2 is handled the same way with rs2. Applies to every capture, including the capture immediately after a load-use bubble.
- Register x0 never bypasses and never triggers load_use.
- Latency: one cycle ID→EX. Load-use costs exactly one bubble: the cycle after the bubble, ex_valid=0, so load_use deasserts and the instruction advances.
- Reset asserted mid-stall or mid-bubble: outputs return to bubble immediately; no hazard state survives.

Optional Feature:
- Macro STALL_CNT_EN.
- Defined: adds output port bubble_cnt (32 bits). It increments by 1 on each edge where a load-use bubble is inserted (case 3 only, not flush or stall_in), wraps from 0xFFFFFFFF to 0, and resets to 0.
- Undefined: no counter and no port; all other behaviour is identical.

Test Plan:
- Reset with id_valid=1, then release → ex_valid=0, ex_rd=0 until first edge; next edge captures id_pc=0x100, ex_pc=0x100, ex_valid=1.
- EX holds LOAD with rd=5; ID has add using rs2=5 → id_stall=1 for one cycle and ex_valid=0. The next edge captures the add, and bubble_cnt goes 0→1 when STALL_CNT_EN is defined.
- Same scenario with ex_rd=0, or with id_uses_rs2=0 → no stall, capture proceeds directly.
- wb_we=1, wb_rd=3, wb_data=0xDEADBEEF, id_rs1=3, id_data1=0x11 → ex_data1=0xDEADBEEF. With wb_rd=0 → ex_data1=0x11.
- stall_in=1 for 3 cycles with changing ID inputs → ex_* constant and id_stall=1. Assert flush together with stall_in → id_stall=0, EX becomes bubble.
- Counter at 0xFFFFFFFF (forced) plus one load-use bubble → bubble_cnt=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use bubble insertion, stall/flush handling and WB->ID operand bypass.
// Optional bubble counter port enabled by defining STALL_CNT_EN.

`ifndef LOAD_IR
`define LOAD_IR     4'd0
`endif
`ifndef REG_IMM_IR
`define REG_IMM_IR  4'd2
`endif
`ifndef REG_REG_IR
`define REG_REG_IR  4'd3
`endif
`ifndef ADD_FUNCT3
`define ADD_FUNCT3  3'b000
`endif

module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_in,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [3:0]      id_ir_type,
  input  logic [2:0]      id_funct3,
  input  logic [6:0]      id_funct7,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic            id_reg_we,
  input  logic [XLEN-1:0] id_data1,
  input  logic [XLEN-1:0] id_data2,
  input  logic [XLEN-1:0] id_imm,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_data1,
  output logic [XLEN-1:0] ex_data2,
  output logic [XLEN-1:0] ex_imm,
  output logic [3:0]      ex_ir_type,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_we
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]     bubble_cnt
`endif
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [3:0]      ir_type;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic            reg_we;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] imm;
  } ex_t;

  localparam ex_t BUBBLE = '{
    valid:   1'b0,
    pc:      '0,
    ir_type: `REG_IMM_IR,
    funct3:  `ADD_FUNCT3,
    funct7:  7'd0,
    rd:      5'd0,
    reg_we:  1'b0,
    data1:   '0,
    data2:   '0,
    imm:     '0
  };

  ex_t ex_q;
  ex_t capture;
  logic load_use;
  logic byp1;
  logic byp2;

  // x0 is excluded on both paths: it is hard-wired zero, so neither a WB to it nor a load into it matters.
  assign load_use = ex_q.valid && (ex_q.ir_type == `LOAD_IR) && (ex_q.rd != 5'd0) && id_valid &&
                    ((id_uses_rs1 && (id_rs1 == ex_q.rd)) || (id_uses_rs2 && (id_rs2 == ex_q.rd)));

  assign id_stall = !flush && (stall_in || load_use);

  assign byp1 = wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs1);
  assign byp2 = wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs2);

  always_comb begin
    // NOTE: assign the whole struct a default first so no path through this block can infer a latch.
    capture = BUBBLE;
    if (id_valid) begin
      capture.valid   = 1'b1;
      capture.pc      = id_pc;
      capture.ir_type = id_ir_type;
      capture.funct3  = id_funct3;
      capture.funct7  = id_funct7;
      capture.rd      = id_rd;
      capture.reg_we  = id_reg_we;
      capture.data1   = byp1 ? wb_data : id_data1;
      capture.data2   = byp2 ? wb_data : id_data2;
      capture.imm     = id_imm;
    end
  end

  // Priority: flush, then downstream stall (hold), then load-use bubble, then capture.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (!rst_n)         ex_q <= BUBBLE;
    else if (flush)     ex_q <= BUBBLE;
    else if (stall_in)  ex_q <= ex_q;
    else if (load_use)  ex_q <= BUBBLE;
    else                ex_q <= capture;
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             bubble_cnt <= 32'd0;
    else if (!flush && !stall_in && load_use) bubble_cnt <= bubble_cnt + 32'd1;
  end
`endif

  assign ex_valid   = ex_q.valid;
  assign ex_pc      = ex_q.pc;
  assign ex_ir_type = ex_q.ir_type;
  assign ex_funct3  = ex_q.funct3;
  assign ex_funct7  = ex_q.funct7;
  assign ex_rd      = ex_q.rd;
  assign ex_reg_we  = ex_q.reg_we;
  assign ex_data1   = ex_q.data1;
  assign ex_data2   = ex_q.data2;
  assign ex_imm     = ex_q.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes the expected EX state, a monitor pops and compares
// one cycle later. Counter checks are active when STALL_CNT_EN is defined.

module tb_id_ex_stage;

  localparam logic [3:0] LOAD    = 4'd0;
  localparam logic [3:0] REG_IMM = 4'd2;
  localparam logic [3:0] REG_REG = 4'd3;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  ir_type;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        reg_we;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] imm;
    logic [31:0] cnt;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_in = 1'b0, flush = 1'b0;
  logic id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_data1 = '0, id_data2 = '0, id_imm = '0;
  logic [3:0] id_ir_type = REG_IMM;
  logic [2:0] id_funct3 = '0;
  logic [6:0] id_funct7 = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_reg_we = 1'b0;
  logic wb_we = 1'b0;
  logic [4:0] wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic id_stall, ex_valid, ex_reg_we;
  logic [31:0] ex_pc, ex_data1, ex_data2, ex_imm;
  logic [3:0] ex_ir_type;
  logic [2:0] ex_funct3;
  logic [6:0] ex_funct7;
  logic [4:0] ex_rd;
`ifdef STALL_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;
  ex_t sb[$];
  logic [31:0] exp_cnt = '0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_ir_type(id_ir_type),
    .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_reg_we(id_reg_we),
    .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
    .ex_ir_type(ex_ir_type), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we)
`ifdef STALL_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ex_t actual();
    ex_t a;
    a = '{valid: ex_valid, pc: ex_pc, ir_type: ex_ir_type, funct3: ex_funct3, funct7: ex_funct7,
          rd: ex_rd, reg_we: ex_reg_we, data1: ex_data1, data2: ex_data2, imm: ex_imm, cnt: 32'd0};
`ifdef STALL_CNT_EN
    a.cnt = bubble_cnt;
`endif
    return a;
  endfunction

  function automatic logic [31:0] cnt_exp();
`ifdef STALL_CNT_EN
    return exp_cnt;
`else
    return 32'd0;
`endif
  endfunction

  function automatic ex_t bub();
    return '{valid: 1'b0, pc: 32'd0, ir_type: REG_IMM, funct3: 3'd0, funct7: 7'd0,
             rd: 5'd0, reg_we: 1'b0, data1: 32'd0, data2: 32'd0, imm: 32'd0, cnt: cnt_exp()};
  endfunction

  // Expected capture of the bench's own ID drive, with hand-chosen operand values.
  function automatic ex_t cap(input logic [31:0] d1, input logic [31:0] d2);
    return '{valid: 1'b1, pc: id_pc, ir_type: id_ir_type, funct3: id_funct3, funct7: id_funct7,
             rd: id_rd, reg_we: id_reg_we, data1: d1, data2: d2, imm: id_imm, cnt: cnt_exp()};
  endfunction

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [3:0] ir,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic we,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    id_valid = v; id_pc = pc; id_ir_type = ir; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_reg_we = we;
    id_data1 = d1; id_data2 = d2; id_imm = imm;
    id_funct3 = pc[4:2]; id_funct7 = {pc[7:2], 1'b1};
  endtask

  // Called just after a negedge with inputs driven: checks id_stall, queues the post-edge EX state.
  task automatic step(input string name, input logic exp_stall, input ex_t exp);
    #1;
    check({name, ".id_stall"}, 256'(id_stall), 256'(exp_stall));
    sb.push_back(exp);
    @(negedge clk);
  endtask

  initial begin : monitor
    ex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ex_state", 256'(actual()), 256'(e));
      end
    end
  end

  ex_t held;

  initial begin : stim
    set_id(1'b1, 32'h100, REG_REG, 5'd2, 5'd4, 5'd1, 1'b1, 1'b1, 1'b1, 32'hA, 32'hB, 32'h0);
    repeat (2) @(posedge clk);
    #1 check("reset_state", 256'(actual()), 256'(bub()));
    @(negedge clk);
    rst_n = 1'b1;
    step("first_capture", 1'b0, cap(32'hA, 32'hB));

    set_id(1'b1, 32'h104, LOAD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 32'h8);
    step("load_rd5", 1'b0, cap(32'h40, 32'h0));

    set_id(1'b1, 32'h108, REG_REG, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 32'h66, 32'h77, 32'h0);
    exp_cnt = 32'd1;
    step("load_use_bubble", 1'b1, bub());
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
    step("after_bubble_bypass", 1'b0, cap(32'h66, 32'h55));
    wb_we = 1'b0;

    set_id(1'b1, 32'h10C, LOAD, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0);
    step("load_rd0", 1'b0, cap(32'h40, 32'h0));
    set_id(1'b1, 32'h110, REG_REG, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
    step("rd0_no_stall", 1'b0, cap(32'h0, 32'h0));

    set_id(1'b1, 32'h114, LOAD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 32'h4);
    step("load_rd5_b", 1'b0, cap(32'h40, 32'h0));
    set_id(1'b1, 32'h118, REG_IMM, 5'd9, 5'd5, 5'd10, 1'b1, 1'b0, 1'b1, 32'h99, 32'h5, 32'h3);
    step("no_uses_rs2", 1'b0, cap(32'h99, 32'h5));

    set_id(1'b1, 32'h11C, REG_REG, 5'd3, 5'd4, 5'd11, 1'b1, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0);
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    step("bypass_rs1", 1'b0, cap(32'hDEADBEEF, 32'h22));
    set_id(1'b1, 32'h120, REG_REG, 5'd0, 5'd4, 5'd12, 1'b1, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0);
    wb_rd = 5'd0;
    held = cap(32'h11, 32'h22);
    step("no_bypass_x0", 1'b0, held);
    wb_we = 1'b0;

    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'h200 + 32'(i * 4), REG_REG, 5'd1, 5'd2, 5'd13, 1'b1, 1'b1, 1'b1,
             32'h1000 + 32'(i), 32'h2000, 32'h0);
      step("stall_hold", 1'b1, held);
    end
    flush = 1'b1;
    step("flush_over_stall", 1'b0, bub());
    flush = 1'b0; stall_in = 1'b0;

    set_id(1'b0, 32'h300, REG_REG, 5'd1, 5'd2, 5'd14, 1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3);
    step("invalid_id_bubble", 1'b0, bub());

    set_id(1'b1, 32'h304, LOAD, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0);
    step("load_rd8", 1'b0, cap(32'h40, 32'h0));
    set_id(1'b1, 32'h308, REG_REG, 5'd8, 5'd2, 5'd15, 1'b1, 1'b1, 1'b1, 32'h88, 32'h2, 32'h0);
    flush = 1'b1;
    step("flush_over_load_use", 1'b0, bub());
    flush = 1'b0;

    set_id(1'b1, 32'h30C, LOAD, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0);
    held = cap(32'h40, 32'h0);
    step("load_rd8_b", 1'b0, held);
    set_id(1'b1, 32'h310, REG_REG, 5'd8, 5'd2, 5'd16, 1'b1, 1'b1, 1'b1, 32'h88, 32'h2, 32'h0);
    stall_in = 1'b1;
    step("stall_over_load_use", 1'b1, held);
    stall_in = 1'b0;
    exp_cnt = 32'd2;
    step("load_use_after_stall", 1'b1, bub());
    step("capture_after_bubble", 1'b0, cap(32'h88, 32'h2));

`ifdef STALL_CNT_EN
    force dut.bubble_cnt = 32'hFFFF_FFFF;
    #1 release dut.bubble_cnt;
    exp_cnt = 32'hFFFF_FFFF;
`endif
    set_id(1'b1, 32'h314, LOAD, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0);
    step("load_rd6", 1'b0, cap(32'h40, 32'h0));
    set_id(1'b1, 32'h318, REG_IMM, 5'd6, 5'd0, 5'd17, 1'b1, 1'b0, 1'b1, 32'h6, 32'h0, 32'h1);
    exp_cnt = exp_cnt + 32'd1;
    step("cnt_wrap_bubble", 1'b1, bub());
    held = cap(32'h6, 32'h0);
    step("capture_after_wrap", 1'b0, held);

    stall_in = 1'b1;
    step("stall_before_reset", 1'b1, held);
    rst_n = 1'b0;
    exp_cnt = 32'd0;
    #1 check("reset_mid_stall", 256'(actual()), 256'(bub()));
    check("reset_stall_out", 256'(id_stall), 256'(1'b1));
    stall_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_id(1'b1, 32'h400, REG_REG, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 32'h0);
    step("capture_after_reset", 1'b0, cap(32'h1, 32'h2));

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 256'(sb.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
